// File: rtl/zacore_fetch_buffer.sv
// Purpose : first-word-fall-through instruction buffer between fetch and decode.
// Latency : a push accepted at edge N is visible at the head after edge N (one cycle).
// Backpr. : o_full (registered) stalls fetch; pushes while full are dropped, pops while empty ignored.
//
// Ports:
//   i_clk, i_rst                    sole clock, synchronous active-high reset
//   i_push, i_push_inst, i_push_pc  instruction from fetch (accepted when !o_full)
//   o_full                          DEPTH entries held; fetch stall
//   o_valid, o_inst, o_pc           head entry to decode (zeroed while empty)
//   i_pop                           decode consumes the head (accepted when o_valid)
//   i_invalidate                    flush all entries at the next edge
//   o_count                         occupied entries
module zacore_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [31:0]                i_push_inst,
  input  logic [31:0]                i_push_pc,
  output logic                       o_full,
  output logic                       o_valid,
  output logic [31:0]                o_inst,
  output logic [31:0]                o_pc,
  input  logic                       i_pop,
  input  logic                       i_invalidate,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Instruction/PC storage. Deliberately not reset: contents are never
  // observable while the buffer is empty, so only the pointers need clearing.
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push_acc;
  logic pop_acc;
  logic wr_en;

  // Status comes purely from registered count, so o_full never depends
  // combinationally on i_pop (no push-through when full).
  assign o_valid = (count_q != '0);
  assign o_full  = (count_q == DEPTH_C);
  assign o_count = count_q;

  assign push_acc = i_push & ~o_full;
  assign pop_acc  = i_pop & o_valid;

  // Storage is only written when the push actually lands; a flush in the
  // same cycle discards it.
  assign wr_en = push_acc & ~i_invalidate & ~i_rst;

  // Next-state pointer and occupancy logic. DEPTH is a power of two, so the
  // PW-bit pointer increment wraps from DEPTH-1 to 0 on its own.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_invalidate) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_acc) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop_acc) begin
        head_d = head_q + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      inst_mem[tail_q] <= i_push_inst;
      pc_mem[tail_q]   <= i_push_pc;
    end
  end

  // Fall-through head read; forced to zero when empty so stale storage
  // never leaks to decode.
  always_comb begin
    o_inst = '0;
    o_pc   = '0;
    if (o_valid) begin
      o_inst = inst_mem[head_q];
      o_pc   = pc_mem[head_q];
    end
  end

endmodule
